// File: rtl/dmp_cfg_writer_pkg.sv
// Shared PMP / JITDomain configuration types, request kinds and writer FSM states.
// Field layouts follow the riscv package so checker instances see identical encodings.
package dmp_cfg_writer_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;

    typedef logic [1:0] dmp_domain_t;

    localparam dmp_domain_t DOMI = 2'd0;

    typedef struct packed {
        logic        locked;
        logic [4:0]  reserved;
        dmp_domain_t domain;
    } dmpcfg_t;

    typedef enum logic [1:0] {
        DMP_REQ_PMPCFG  = 2'd0,
        DMP_REQ_DMPCFG  = 2'd1,
        DMP_REQ_PMPADDR = 2'd2,
        DMP_REQ_DOMSW   = 2'd3
    } dmp_req_kind_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_FLUSH = 2'd2,
        S_RESP  = 2'd3
    } dmp_state_t;

    localparam int unsigned PMPCFG_W = $bits(pmpcfg_t);
    localparam int unsigned DMPCFG_W = $bits(dmpcfg_t);
    localparam int unsigned DOM_W    = $bits(dmp_domain_t);

endpackage

// File: rtl/dmp_lock_check.sv
// Combinational legality and no-op detection for one captured configuration request.
module dmp_lock_check
    import dmp_cfg_writer_pkg::*;
#(
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  dmp_req_kind_t               i_kind,
    input  logic [3:0]                  i_idx,
    input  logic [PMP_LEN-1:0]          i_data,
    input  priv_lvl_t                   i_priv,
    input  pmpcfg_t [15:0]              i_pmpconf,
    input  dmpcfg_t [15:0]              i_dmpconf,
    input  logic [15:0][PMP_LEN-1:0]    i_conf_addr,
    input  dmp_domain_t                 i_curdom,
    output logic                        o_legal,
    output logic                        o_unchanged
);

    localparam logic [4:0] NR_E = 5'(NR_ENTRIES);

    logic [4:0]  w_idx_nxt;
    logic        w_idx_oor;
    logic        w_locked;
    logic        w_tor_locked;
    pmpcfg_t     w_new_pmp;
    dmpcfg_t     w_new_dmp;
    dmp_domain_t w_new_dom;

    always_comb begin
        w_idx_nxt    = {1'b0, i_idx} + 5'd1;
        w_idx_oor    = ({1'b0, i_idx} >= NR_E);
        w_locked     = i_pmpconf[i_idx].locked & i_dmpconf[i_idx].locked;
        // A locked TOR entry also freezes the address below it, which forms its lower bound.
        w_tor_locked = (w_idx_nxt < NR_E)
                     && i_pmpconf[w_idx_nxt[3:0]].locked
                     && i_dmpconf[w_idx_nxt[3:0]].locked
                     && (i_pmpconf[w_idx_nxt[3:0]].addr_mode == TOR);
        w_new_pmp    = pmpcfg_t'(i_data[PMPCFG_W-1:0]);
        w_new_dmp    = dmpcfg_t'(i_data[DMPCFG_W-1:0]);
        w_new_dom    = dmp_domain_t'(i_data[DOM_W-1:0]);

        o_legal      = (i_priv == PRIV_LVL_M);
        o_unchanged  = 1'b0;
        case (i_kind)
            DMP_REQ_PMPCFG: begin
                if (w_idx_oor || w_locked ||
                    (!w_new_pmp.access_type.r && w_new_pmp.access_type.w))
                    o_legal = 1'b0;
                o_unchanged = (w_new_pmp == i_pmpconf[i_idx]);
            end
            DMP_REQ_DMPCFG: begin
                if (w_idx_oor || w_locked)
                    o_legal = 1'b0;
                o_unchanged = (w_new_dmp == i_dmpconf[i_idx]);
            end
            DMP_REQ_PMPADDR: begin
                if (w_idx_oor || w_locked || w_tor_locked)
                    o_legal = 1'b0;
                o_unchanged = (i_data == i_conf_addr[i_idx]);
            end
            default: begin
                o_unchanged = (w_new_dom == i_curdom);
            end
        endcase
    end

endmodule

// File: rtl/dmp_cfg_writer.sv
// Write-side owner of PMP/DMP configuration: accepts one request at a time,
// enforces lock rules, commits changes and holds a flush handshake until acknowledged.
module dmp_cfg_writer
    import dmp_cfg_writer_pkg::*;
#(
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  priv_lvl_t                   priv_lvl_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  dmp_req_kind_t               req_kind_i,
    input  logic [3:0]                  req_idx_i,
    input  logic [PMP_LEN-1:0]          req_data_i,
    output logic                        rsp_valid_o,
    output logic                        rsp_err_o,
    output logic                        flush_req_o,
    input  logic                        flush_ack_i,
    output pmpcfg_t [15:0]              pmpconf_o,
    output dmpcfg_t [15:0]              dmpconf_o,
    output logic [15:0][PMP_LEN-1:0]    conf_addr_o,
    output dmp_domain_t                 curdom_o
);

    dmp_state_t               r_state;
    dmp_state_t               w_state_nxt;
    dmp_req_kind_t            r_kind;
    logic [3:0]               r_idx;
    logic [PMP_LEN-1:0]       r_data;
    priv_lvl_t                r_priv;
    logic                     r_err;
    pmpcfg_t [15:0]           r_pmpconf;
    dmpcfg_t [15:0]           r_dmpconf;
    logic [15:0][PMP_LEN-1:0] r_conf_addr;
    dmp_domain_t              r_curdom;

    logic w_legal;
    logic w_unchanged;
    logic w_accept;
    logic w_commit;
    logic w_ready;
    logic w_rsp_valid;
    logic w_flush;

    dmp_lock_check #(
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) u_lock_check (
        .i_kind      (r_kind),
        .i_idx       (r_idx),
        .i_data      (r_data),
        .i_priv      (r_priv),
        .i_pmpconf   (r_pmpconf),
        .i_dmpconf   (r_dmpconf),
        .i_conf_addr (r_conf_addr),
        .i_curdom    (r_curdom),
        .o_legal     (w_legal),
        .o_unchanged (w_unchanged)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_flush     = 1'b0;
        w_commit    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready  = 1'b1;
                w_accept = req_valid_i;
                if (req_valid_i)
                    w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_commit    = w_legal && !w_unchanged;
                w_state_nxt = w_commit ? S_FLUSH : S_RESP;
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (flush_ack_i)
                    w_state_nxt = S_RESP;
            end
            default: begin
                w_rsp_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_err       <= 1'b0;
            r_pmpconf   <= '0;
            r_dmpconf   <= '0;
            r_conf_addr <= '0;
            r_curdom    <= DOMI;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CHECK)
                r_err <= !w_legal;
            if (w_commit) begin
                case (r_kind)
                    DMP_REQ_PMPCFG:  r_pmpconf[r_idx]   <= pmpcfg_t'(r_data[PMPCFG_W-1:0]);
                    DMP_REQ_DMPCFG:  r_dmpconf[r_idx]   <= dmpcfg_t'(r_data[DMPCFG_W-1:0]);
                    DMP_REQ_PMPADDR: r_conf_addr[r_idx] <= r_data;
                    default:         r_curdom           <= dmp_domain_t'(r_data[DOM_W-1:0]);
                endcase
            end
        end
    end

    // Captured request is only meaningful once the FSM leaves IDLE, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_kind <= req_kind_i;
            r_idx  <= req_idx_i;
            r_data <= req_data_i;
            r_priv <= priv_lvl_i;
        end
    end

    assign req_ready_o = w_ready;
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_err_o   = w_rsp_valid & r_err;
    assign flush_req_o = w_flush;
    assign pmpconf_o   = r_pmpconf;
    assign dmpconf_o   = r_dmpconf;
    assign conf_addr_o = r_conf_addr;
    assign curdom_o    = r_curdom;

endmodule

// File: tb/tb_dmp_cfg_writer.sv
// Directed bench for dmp_cfg_writer: lock/TOR-lock rules, no-op detection,
// flush handshake timing and reset during an outstanding flush.
module tb_dmp_cfg_writer;
    import dmp_cfg_writer_pkg::*;

    localparam int unsigned PMP_LEN    = 32;
    localparam int unsigned NR_ENTRIES = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    priv_lvl_t                priv;
    logic                     req_valid;
    logic                     req_ready;
    dmp_req_kind_t            req_kind;
    logic [3:0]               req_idx;
    logic [PMP_LEN-1:0]       req_data;
    logic                     rsp_valid;
    logic                     rsp_err;
    logic                     flush_req;
    logic                     flush_ack;
    pmpcfg_t [15:0]           pmpconf;
    dmpcfg_t [15:0]           dmpconf;
    logic [15:0][PMP_LEN-1:0] conf_addr;
    dmp_domain_t              curdom;

    int n_checks = 0;
    int n_errors = 0;

    dmp_cfg_writer #(
        .PMP_LEN    (PMP_LEN),
        .NR_ENTRIES (NR_ENTRIES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .priv_lvl_i  (priv),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_kind_i  (req_kind),
        .req_idx_i   (req_idx),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .flush_req_o (flush_req),
        .flush_ack_i (flush_ack),
        .pmpconf_o   (pmpconf),
        .dmpconf_o   (dmpconf),
        .conf_addr_o (conf_addr),
        .curdom_o    (curdom)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in IDLE; returns in the CHECK cycle (N+1).
    task automatic send(input dmp_req_kind_t k, input logic [3:0] idx,
                        input logic [PMP_LEN-1:0] data, input priv_lvl_t p);
        check_val("ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_kind  = k;
        req_idx   = idx;
        req_data  = data;
        priv      = p;
        tick();
        req_valid = 1'b0;
        check_val("ready_busy", 64'(req_ready), 64'd0);
        check_val("rsp_early", 64'(rsp_valid), 64'd0);
    endtask

    // Commit path with ack in the first FLUSH cycle: rsp at N+3.
    task automatic run_commit(input string tag);
        tick();
        check_val({tag, "_flush"}, 64'(flush_req), 64'd1);
        check_val({tag, "_norsp"}, 64'(rsp_valid), 64'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        check_val({tag, "_rsp"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_err"}, 64'(rsp_err), 64'd0);
        check_val({tag, "_flush_off"}, 64'(flush_req), 64'd0);
        tick();
        check_val({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    // Reject or no-op path: rsp at N+2, no flush.
    task automatic run_resp(input string tag, input logic exp_err);
        tick();
        check_val({tag, "_rsp"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        check_val({tag, "_noflush"}, 64'(flush_req), 64'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_kind  = DMP_REQ_PMPCFG;
        req_idx   = '0;
        req_data  = '0;
        priv      = PRIV_LVL_M;
        flush_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp", 64'(rsp_valid), 64'd0);
        check_val("rst_flush", 64'(flush_req), 64'd0);
        check_val("rst_pmp0", 64'(pmpconf[0]), 64'd0);
        check_val("rst_curdom", 64'(curdom), 64'(DOMI));

        // PMPCFG 0 = TOR,RWX; ack at N+4, rsp at N+5
        send(DMP_REQ_PMPCFG, 4'd0, 32'h0F, PRIV_LVL_M);
        tick();
        check_val("p0_val", 64'(pmpconf[0]), 64'h0F);
        check_val("p0_flush_n2", 64'(flush_req), 64'd1);
        tick();
        check_val("p0_flush_n3", 64'(flush_req), 64'd1);
        check_val("p0_norsp_n3", 64'(rsp_valid), 64'd0);
        tick();
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        check_val("p0_rsp_n5", 64'(rsp_valid), 64'd1);
        check_val("p0_err_n5", 64'(rsp_err), 64'd0);
        check_val("p0_flush_n5", 64'(flush_req), 64'd0);
        tick();
        check_val("p0_idle", 64'(rsp_valid), 64'd0);

        // Lock entry 1 in both tables with TOR mode
        send(DMP_REQ_PMPCFG, 4'd1, 32'h8F, PRIV_LVL_M);
        run_commit("p1_lock");
        check_val("p1_val", 64'(pmpconf[1]), 64'h8F);
        send(DMP_REQ_DMPCFG, 4'd1, 32'h80, PRIV_LVL_M);
        run_commit("d1_lock");
        check_val("d1_val", 64'(dmpconf[1]), 64'h80);

        send(DMP_REQ_PMPADDR, 4'd0, 32'h1000, PRIV_LVL_M);
        run_resp("a0_torlock", 1'b1);
        check_val("a0_unchanged", 64'(conf_addr[0]), 64'd0);
        send(DMP_REQ_PMPCFG, 4'd1, 32'h0F, PRIV_LVL_M);
        run_resp("p1_frozen", 1'b1);
        check_val("p1_kept", 64'(pmpconf[1]), 64'h8F);
        send(DMP_REQ_PMPADDR, 4'd1, 32'h3000, PRIV_LVL_M);
        run_resp("a1_locked", 1'b1);

        send(DMP_REQ_PMPADDR, 4'd2, 32'h2000, PRIV_LVL_M);
        run_commit("a2_write");
        check_val("a2_val", 64'(conf_addr[2]), 64'h2000);

        // pmp lock alone does not freeze the entry
        send(DMP_REQ_PMPCFG, 4'd2, 32'h80, PRIV_LVL_M);
        run_commit("p2_half");
        check_val("p2_half_val", 64'(pmpconf[2]), 64'h80);
        send(DMP_REQ_PMPCFG, 4'd2, 32'h00, PRIV_LVL_M);
        run_commit("p2_clear");
        check_val("p2_clear_val", 64'(pmpconf[2]), 64'h00);

        send(DMP_REQ_PMPCFG, 4'd3, 32'h02, PRIV_LVL_M);
        run_resp("p3_wnor", 1'b1);
        check_val("p3_kept", 64'(pmpconf[3]), 64'h00);
        send(DMP_REQ_PMPADDR, 4'(NR_ENTRIES), 32'h44, PRIV_LVL_M);
        run_resp("a_oor", 1'b1);
        send(DMP_REQ_PMPADDR, 4'd3, 32'h55, PRIV_LVL_U);
        run_resp("a3_priv_u", 1'b1);
        check_val("a3_kept", 64'(conf_addr[3]), 64'd0);
        send(DMP_REQ_PMPADDR, 4'd2, 32'h2000, PRIV_LVL_M);
        run_resp("a2_noop", 1'b0);

        send(DMP_REQ_DOMSW, 4'd0, 32'h3, PRIV_LVL_M);
        run_commit("dom3");
        check_val("dom3_val", 64'(curdom), 64'd3);
        send(DMP_REQ_DOMSW, 4'd0, 32'h3, PRIV_LVL_M);
        run_resp("dom3_noop", 1'b0);
        send(DMP_REQ_DOMSW, 4'd0, 32'h1, PRIV_LVL_S);
        run_resp("dom_priv_s", 1'b1);
        check_val("dom_kept", 64'(curdom), 64'd3);

        // Reset while the flush is outstanding
        send(DMP_REQ_PMPCFG, 4'd3, 32'h0F, PRIV_LVL_M);
        tick();
        check_val("rf_flush", 64'(flush_req), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rf_flush_drop", 64'(flush_req), 64'd0);
        check_val("rf_rsp", 64'(rsp_valid), 64'd0);
        check_val("rf_pmp1", 64'(pmpconf[1]), 64'd0);
        check_val("rf_pmp3", 64'(pmpconf[3]), 64'd0);
        check_val("rf_dmp1", 64'(dmpconf[1]), 64'd0);
        check_val("rf_addr2", 64'(conf_addr[2]), 64'd0);
        check_val("rf_curdom", 64'(curdom), 64'(DOMI));
        tick();
        check_val("rf_rsp_after", 64'(rsp_valid), 64'd0);
        check_val("rf_ready", 64'(req_ready), 64'd1);

        // Locks cleared by reset: address 0 is writable again
        send(DMP_REQ_PMPADDR, 4'd0, 32'h1000, PRIV_LVL_M);
        run_commit("a0_after_rst");
        check_val("a0_after_val", 64'(conf_addr[0]), 64'h1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmp_cfg_writer.md
Name: dmp_cfg_writer

Overview:
- Write-side owner of the PMP and JITDomain (DMP) configuration state consumed by the combinational PMP checker.
- Accepts serialized CSR-side write requests (pmpcfg, dmpcfg, pmpaddr, domain switch) over a valid/ready channel and enforces lock and TOR-lock rules.
- Commits legal changes and holds a TLB/translation flush handshake until acknowledged.
- Drives pmpconf/dmpconf/conf_addr/curdom directly into every checker instance.

Parameters:
- PMP_LEN, 32, width of each pmpaddr register (rv64: 54).
- NR_ENTRIES, 4, implemented entries (0..16); entries at or above NR_ENTRIES read as zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- priv_lvl_i  in  riscv::priv_lvl_t  privilege of requester
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_kind_i  in  riscv::dmp_req_kind_t (2)  PMPCFG=0, DMPCFG=1, PMPADDR=2, DOMSW=3
- req_idx_i  in  4  entry index (ignored for DOMSW)
- req_data_i  in  PMP_LEN  write data; cfg kinds use low bits cast to the target type
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_err_o  out  1  request dropped (qualified by rsp_valid_o)
- flush_req_o  out  1  flush request, level, held until ack
- flush_ack_i  in  1  flush done
- pmpconf_o  out  riscv::pmpcfg_t [15:0]  to checker
- dmpconf_o  out  riscv::dmpcfg_t [15:0]  to checker
- conf_addr_o  out  [15:0][PMP_LEN-1:0]  to checker
- curdom_o  out  riscv::dmp_domain_t  current domain to checker

Behaviour:
- Reset (synchronous, rst_i=1 at clk edge): all pmpconf/dmpconf/conf_addr = 0 (OFF, unlocked, domain 0); curdom_o = riscv::DOMI; FSM=IDLE; rsp_valid_o=0, rsp_err_o=0, flush_req_o=0, req_ready_o=1 after reset releases. Reset wins over any in-flight request or flush: the request is lost, no response, flush_req_o drops immediately.
- Effective lock L[i] = pmpconf[i].locked & dmpconf[i].locked.
- Legality (CHECK); any violation gives err=1 and no state change:
  - priv_lvl_i captured at accept must be M;
  - idx >= NR_ENTRIES (except DOMSW);
  - PMPCFG/DMPCFG to entry with L[i];
  - PMPADDR to entry i with L[i], or with L[i+1] and pmpconf[i+1].addr_mode==TOR (i+1<NR_ENTRIES);
  - PMPCFG data with R=0, W=1 (reserved).
- FSM:
  - IDLE: req_ready_o=1. On handshake, capture kind/idx/data/priv and go to CHECK.
  - CHECK: req_ready_o=0. Illegal: go to RESP with err=1. Legal but new value equals current value: go to RESP with err=0, no flush. Legal and different: write the register at the end of this cycle and go to FLUSH.
  - FLUSH: flush_req_o=1. On flush_ack_i=1, go to RESP. flush_ack_i is ignored outside FLUSH.
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Latency from handshake at cycle N:
  - reject or no-op: rsp_valid_o at N+2;
  - commit: outputs updated N+2, flush_req_o from N+2, rsp_valid_o the cycle after the ack cycle (minimum N+3).
- One request in flight; no back-to-back acceptance (ready low from N+1 until return to IDLE).
- DOMSW: curdom_o <= req_data_i[domain width-1:0]. Switching to the current domain is a no-op.
- Writing a lock bit is allowed. Once both lock bits are set, the entry is frozen until reset.
- Width: PMPCFG uses req_data_i[7:0]; DMPCFG uses the low $bits(riscv::dmpcfg_t) bits; upper bits ignored.

Decomposition:
- riscv package: add dmp_req_kind_t enum. pmpcfg_t, dmpcfg_t, dmp_domain_t, DOMI, priv_lvl_t are reused as-is.
- One combinational sub-module, dmp_lock_check: inputs captured request plus current config; outputs legal and unchanged flags.
- FSM and registers stay in dmp_cfg_writer.

Test Plan:
- Reset then PMPCFG idx0 data 0x0F (TOR,RWX) from M -> pmpconf_o[0]=0x0F at N+2, flush_req_o high until ack at N+4, rsp_valid_o=1 rsp_err_o=0 at N+5.
- Set pmpconf[1].locked and dmpconf[1].locked (both with TOR), then PMPADDR idx0 data 0x1000 -> rsp_err_o=1 at N+2, conf_addr_o[0] unchanged, no flush.
- Only pmpconf[2].locked set (dmp unlocked), PMPCFG idx2 data 0x00 -> accepted, pmpconf_o[2]=0.
- PMPCFG idx1 data 0x02 (W without R) -> err=1; PMPADDR idx NR_ENTRIES from M -> err=1; any request from priv U -> err=1.
- DOMSW data 3 from M -> curdom_o=3, flush handshake. Repeat DOMSW 3 -> rsp at N+2, no flush_req_o.
- Assert rst_i in FLUSH state -> next cycle flush_req_o=0, all config zero, curdom_o=DOMI, no rsp_valid_o.
